// File: rtl/pid_channel_scheduler.sv
// Round-robin scheduler sharing one PID core across NUM_CH channels, with a per-channel gain bank.
// Optional macro GAIN_CACHE_EN: skip the gain reload when the same clean channel is granted again.
module pid_channel_scheduler #(
    parameter int D_WIDTH = 18,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = $clog2(NUM_CH),
    parameter int PID_LAT = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NUM_CH-1:0]         i_req,
    input  logic [NUM_CH*D_WIDTH-1:0] i_target_flat,
    input  logic [NUM_CH*D_WIDTH-1:0] i_meas_flat,
    output logic [NUM_CH-1:0]         o_ack,
    input  logic                      i_cfg_we,
    input  logic [CH_W-1:0]           i_cfg_ch,
    input  logic [1:0]                i_cfg_idx,
    input  logic [D_WIDTH-1:0]        i_cfg_data,
    output logic                      o_pid_we_n,
    output logic [D_WIDTH-1:0]        o_pid_addr,
    output logic [D_WIDTH-1:0]        o_pid_data,
    output logic                      o_pid_iter,
    output logic [D_WIDTH-1:0]        o_pid_target,
    output logic [D_WIDTH-1:0]        o_pid_meas,
    input  logic [D_WIDTH-1:0]        i_pid_out,
    output logic                      o_res_valid,
    output logic [CH_W-1:0]           o_res_ch,
    output logic [D_WIDTH-1:0]        o_res_data,
    output logic                      o_busy
);
    // state | meaning
    // IDLE  | waiting for any request, round-robin pick on entry to LOAD/ITER
    // LOAD  | four gain writes (kp, ki, kd_1, kd_2) of cur_ch into the core
    // ITER  | pid_iter held for PID_LAT cycles with cur_ch target/meas
    // DONE  | result, channel tag and ack presented for one cycle
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

    localparam int LAT_W = (PID_LAT > 1) ? $clog2(PID_LAT) : 1;

    state_t               r_state;
    logic [CH_W-1:0]      r_cur_ch;
    logic [CH_W-1:0]      r_rr;
    logic [1:0]           r_load_cnt;
    logic [LAT_W-1:0]     r_lat_cnt;
    logic [D_WIDTH-1:0]   r_gain [NUM_CH][4];
    logic                 r_pid_we_n;
    logic [D_WIDTH-1:0]   r_pid_addr;
    logic [D_WIDTH-1:0]   r_pid_data;
    logic                 r_pid_iter;
    logic                 r_res_valid;
    logic [CH_W-1:0]      r_res_ch;
    logic [NUM_CH-1:0]    r_ack;
`ifdef GAIN_CACHE_EN
    logic [CH_W-1:0]      r_last_ch;
    logic                 r_cache_valid;
    logic                 r_dirty;
`endif

    logic [CH_W-1:0]      w_grant;
    logic                 w_found;
    logic                 w_cfg_ok;
    logic [1:0]           w_next_idx;
    int                   w_idx;

    // First requester at or after the rr pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = (int'(r_rr) + i) % NUM_CH;
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_grant = CH_W'(w_idx);
            end
        end
    end

    assign w_cfg_ok   = i_cfg_we && ({1'b0, i_cfg_ch} < (CH_W+1)'(NUM_CH));
    assign w_next_idx = r_load_cnt + 2'd1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cur_ch    <= '0;
            r_rr        <= '0;
            r_load_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_pid_we_n  <= 1'b1;
            r_pid_addr  <= '0;
            r_pid_data  <= '0;
            r_pid_iter  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_ack       <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int g = 0; g < 4; g++)
                    r_gain[c][g] <= '0;
`ifdef GAIN_CACHE_EN
            r_last_ch     <= '0;
            r_cache_valid <= 1'b0;
            r_dirty       <= 1'b0;
`endif
        end else begin
            if (w_cfg_ok)
                r_gain[i_cfg_ch][i_cfg_idx] <= i_cfg_data;
`ifdef GAIN_CACHE_EN
            if (i_cfg_we && i_cfg_ch == r_last_ch)
                r_dirty <= 1'b1;
`endif
            r_pid_we_n  <= 1'b1;
            r_pid_addr  <= '0;
            r_pid_data  <= '0;
            r_pid_iter  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_ack       <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_cur_ch  <= w_grant;
                        r_lat_cnt <= '0;
`ifdef GAIN_CACHE_EN
                        if (r_cache_valid && !r_dirty && w_grant == r_last_ch) begin
                            r_state    <= S_ITER;
                            r_pid_iter <= 1'b1;
                        end else begin
                            r_state       <= S_LOAD;
                            r_load_cnt    <= '0;
                            r_pid_we_n    <= 1'b0;
                            r_pid_data    <= r_gain[w_grant][0];
                            r_last_ch     <= w_grant;
                            r_cache_valid <= 1'b1;
                            // A write landing on this very edge must still force a reload later.
                            r_dirty       <= i_cfg_we && (i_cfg_ch == w_grant);
                        end
`else
                        r_state    <= S_LOAD;
                        r_load_cnt <= '0;
                        r_pid_we_n <= 1'b0;
                        r_pid_data <= r_gain[w_grant][0];
`endif
                    end
                end
                S_LOAD: begin
                    if (r_load_cnt == 2'd3) begin
                        r_state    <= S_ITER;
                        r_lat_cnt  <= '0;
                        r_pid_iter <= 1'b1;
                    end else begin
                        r_load_cnt <= w_next_idx;
                        r_pid_we_n <= 1'b0;
                        r_pid_addr <= D_WIDTH'(w_next_idx);
                        r_pid_data <= r_gain[r_cur_ch][w_next_idx];
                    end
                end
                S_ITER: begin
                    if (r_lat_cnt == LAT_W'(PID_LAT - 1)) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                        r_res_ch    <= r_cur_ch;
                        r_ack       <= NUM_CH'(1) << r_cur_ch;
                    end else begin
                        r_lat_cnt  <= r_lat_cnt + 1'b1;
                        r_pid_iter <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_rr    <= (r_cur_ch == CH_W'(NUM_CH - 1)) ? '0 : r_cur_ch + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Target/measurement are passed live during ITER so the core sees current sensor values.
    assign o_pid_target = (r_state == S_ITER) ? i_target_flat[r_cur_ch*D_WIDTH +: D_WIDTH] : '0;
    assign o_pid_meas   = (r_state == S_ITER) ? i_meas_flat[r_cur_ch*D_WIDTH +: D_WIDTH] : '0;
    assign o_res_data   = (r_state == S_DONE) ? i_pid_out : '0;
    assign o_pid_we_n   = r_pid_we_n;
    assign o_pid_addr   = r_pid_addr;
    assign o_pid_data   = r_pid_data;
    assign o_pid_iter   = r_pid_iter;
    assign o_res_valid  = r_res_valid;
    assign o_res_ch     = r_res_ch;
    assign o_ack        = r_ack;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Directed bench for pid_channel_scheduler with a behavioural PID core and a result scoreboard.
module tb_pid_channel_scheduler;
    localparam int D = 18;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*D-1:0] target_flat, meas_flat;
    logic [N-1:0]   ack;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [1:0]     cfg_idx;
    logic [D-1:0]   cfg_data;
    logic           pid_we_n;
    logic [D-1:0]   pid_addr, pid_data, pid_target, pid_meas, pid_out, res_data;
    logic           pid_iter, res_valid, busy;
    logic [1:0]     res_ch;

    pid_channel_scheduler dut (
        .i_clock(clk), .i_reset(rst), .i_req(req),
        .i_target_flat(target_flat), .i_meas_flat(meas_flat), .o_ack(ack),
        .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_idx(cfg_idx), .i_cfg_data(cfg_data),
        .o_pid_we_n(pid_we_n), .o_pid_addr(pid_addr), .o_pid_data(pid_data),
        .o_pid_iter(pid_iter), .o_pid_target(pid_target), .o_pid_meas(pid_meas),
        .i_pid_out(pid_out), .o_res_valid(res_valid), .o_res_ch(res_ch),
        .o_res_data(res_data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; logic [D-1:0] data; } exp_t;
    exp_t          q[$];
    int            n_pass = 0, n_total = 0, n_fail = 0;
    logic [D-1:0]  sh [N][4];
    logic [D-1:0]  tgt [N];
    logic [D-1:0]  meas [N];
    logic [D-1:0]  core_g [4];

    function automatic logic [D-1:0] fval(input logic [D-1:0] a, b, c, d, t, m);
        logic [D-1:0] r;
        r = a + 3*b + 5*c + 7*d + t - m;
        return r;
    endfunction

    // Behavioural core: gain registers plus one registered output stage.
    always @(posedge clk) begin
        if (pid_we_n === 1'b0) core_g[pid_addr[1:0]] <= pid_data;
        if (pid_iter === 1'b1)
            pid_out <= fval(core_g[0], core_g[1], core_g[2], core_g[3], pid_target, pid_meas);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            chk("res_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("res_ch", res_ch, e.ch);
                chk("res_data", res_data, e.data);
                chk("ack", ack, 4'b0001 << e.ch);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.ch   = ch;
        e.data = fval(sh[ch][0], sh[ch][1], sh[ch][2], sh[ch][3], tgt[ch], meas[ch]);
        q.push_back(e);
    endtask

    task automatic cfg(input int ch, input int idx, input logic [D-1:0] v);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_idx = 2'(idx); cfg_data = v;
        tick();
        cfg_we = 1'b0;
        sh[ch][idx] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < N; c++) for (int g = 0; g < 4; g++) sh[c][g] = '0;
    endtask

    task automatic write_all();
        for (int c = 0; c < N; c++)
            for (int g = 0; g < 4; g++)
                cfg(c, g, 18'(c == 0 ? 100*(g+1) : 37*c + 11*g + 1));
    endtask

    // Runs until n results appear; in release mode each acked channel drops its request.
    task automatic run(input int n, input bit hold);
        int got = 0, cyc = 0;
        while (got < n && cyc < 300) begin
            tick(); cyc++;
            if (res_valid === 1'b1) begin
                got++;
                if (!hold) req = req & ~ack;
            end
        end
        chk("results_seen", got, n);
    endtask

    task automatic wait_load(input int idx, input string tag);
        int cyc = 0;
        while (!(pid_we_n === 1'b0 && pid_addr == 18'(idx)) && cyc < 20) begin
            tick(); cyc++;
        end
        chk(tag, pid_addr, idx);
    endtask

    initial begin
        rst = 1'b1; req = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_idx = '0; cfg_data = '0;
        for (int k = 0; k < N; k++) begin
            tgt[k]  = 18'(1000 + 17*k);
            meas[k] = 18'(300 + 5*k);
            target_flat[k*D +: D] = tgt[k];
            meas_flat[k*D +: D]   = meas[k];
        end
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_we_n", pid_we_n, 1);
        chk("rst_iter", pid_iter, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_ack", ack, 0);
        chk("rst_target", pid_target, 0);

        // 1: single request on channel 0, cycle-exact
        write_all();
        req = 4'b0001; push(0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_we_n", pid_we_n, 0);
            chk("t1_addr", pid_addr, i);
            chk("t1_data", pid_data, 100*(i+1));
        end
        tick();
        chk("t1_iter", pid_iter, 1);
        chk("t1_iter_we_n", pid_we_n, 1);
        chk("t1_target", pid_target, tgt[0]);
        tick();
        chk("t1_valid_c6", res_valid, 1);
        req = req & ~ack;
        tick();
        chk("t1_valid_pulse", res_valid, 0);
        chk("t1_idle_addr", pid_addr, 0);

        // 2: all channels held, fair order from a fresh pointer
        do_reset();
        write_all();
        req = 4'b1111;
        push(0); push(1); push(2); push(3); push(0);
        run(5, 1'b1);
        req = '0;
        tick(); tick();

        // 3: pointer wrap after channel 3
        req = 4'b1000; push(3);
        run(1, 1'b0);
        req = 4'b1001; push(0); push(3);
        run(2, 1'b0);

        // 4: gain write to the channel being loaded, at the same index
        req = 4'b0010; push(1);
        wait_load(2, "t4_load2");
        cfg(1, 2, 18'h155);
        run(1, 1'b0);
        req = 4'b0010; push(1);
        run(1, 1'b0);
        chk("t4_core_kd1", core_g[2], 18'h155);

        // 5: reset mid-load aborts with no result and clears the bank
        req = 4'b0100;
        wait_load(1, "t5_load1");
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_we_n", pid_we_n, 1);
        chk("t5_valid", res_valid, 0);
        for (int c = 0; c < N; c++) for (int g = 0; g < 4; g++) sh[c][g] = '0;
        tick(); tick(); tick();
        chk("t5_no_pending", q.size(), 0);
        req = 4'b0100; push(2);
        run(1, 1'b0);

`ifdef GAIN_CACHE_EN
        // 6: cached channel skips reload until its gains are touched
        cfg(2, 0, 18'd9); cfg(2, 3, 18'd4);
        req = 4'b0100; push(2);
        run(1, 1'b0);
        tick();
        req = 4'b0100; push(2);
        tick();
        chk("t6_skip_we_n", pid_we_n, 1);
        chk("t6_skip_iter", pid_iter, 1);
        tick();
        chk("t6_valid_c2", res_valid, 1);
        req = req & ~ack;
        tick();
        cfg(2, 1, 18'd21);
        req = 4'b0100; push(2);
        tick();
        chk("t6_reload", pid_we_n, 0);
        run(1, 1'b0);
`endif

        tick(); tick();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
